// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NR_RD  = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  function automatic int lo(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/pending_table.sv
// Pending-write scoreboard: one bit per register plus a running count.
module pending_table
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en,
  input  logic [ADDR_WIDTH-1:0]   set_idx,
  input  logic                    clr_en,
  input  logic [ADDR_WIDTH-1:0]   clr_idx,
  output logic [2**ADDR_WIDTH-1:0] pending,
  output logic [ADDR_WIDTH-1:0]   pend_cnt
);
  logic [2**ADDR_WIDTH-1:0] r_pend;
  logic [2**ADDR_WIDTH-1:0] w_pend_n;
  logic [ADDR_WIDTH-1:0]    r_cnt;
  logic w_set;
  logic w_clr;
  logic w_inc;
  logic w_dec;

  always_comb begin
    w_set = set_en && (set_idx != ADDR_WIDTH'(ZERO_REG));
    w_clr = clr_en && (clr_idx != ADDR_WIDTH'(ZERO_REG));
    w_inc = w_set && !r_pend[set_idx];
    // a set on the same index overrides the clear
    w_dec = w_clr && r_pend[clr_idx] &&
            !(w_set && set_idx == clr_idx);
    w_pend_n = r_pend;
    if (w_clr) w_pend_n[clr_idx] = 1'b0;
    if (w_set) w_pend_n[set_idx] = 1'b1;
    w_pend_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_n;
      if (w_inc && !w_dec)
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
      else if (w_dec && !w_inc)
        r_cnt <= r_cnt - ADDR_WIDTH'(1);
    end
  end

  assign pending  = r_pend;
  assign pend_cnt = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with pending-write scoreboard
// and optional same-cycle writeback bypass.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int NR_READ    = NR_RD,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          issue_en,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rready,
  output logic [ADDR_WIDTH-1:0]         pend_cnt,
  output logic                          idle
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]      w_pend;
  logic                  w_wr;

  assign w_wr = wen && (waddr != ADDR_WIDTH'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        r_rf[k] <= '0;
    end else if (w_wr) begin
      r_rf[waddr] <= wdata;
    end
  end

  pending_table #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pend (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue_en),
    .set_idx (issue_rd),
    .clr_en  (wen),
    .clr_idx (waddr),
    .pending (w_pend),
    .pend_cnt(pend_cnt)
  );

  assign idle = (pend_cnt == '0);

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_rdy;

    assign w_ra = raddr[lo(i, ADDR_WIDTH) +: ADDR_WIDTH];

    always_comb begin
      w_rd  = r_rf[w_ra];
      w_rdy = !w_pend[w_ra];
      if (w_ra == ADDR_WIDTH'(ZERO_REG)) begin
        w_rd  = '0;
        w_rdy = 1'b1;
      end else if (BYPASS != 0 && wen && waddr == w_ra) begin
        w_rd  = wdata;
        w_rdy = 1'b1;
      end
    end

    assign rdata[lo(i, DATA_WIDTH) +: DATA_WIDTH] = w_rd;
    assign rready[i] = w_rdy;
  end
endmodule
